// File: rtl/i2c_pkg.sv
// i2c_pkg: I2C master command opcodes and poller FSM states, shared with the I2C master.
package i2c_pkg;
  typedef enum logic [1:0] {START = 2'd0, WRITE = 2'd1, READ = 2'd2, STOP = 2'd3} i2c_op_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ABORT} poll_state_t;
endpackage

// File: rtl/i2c_sensor_poller_if.sv
// i2c_sensor_poller_if: byte-level command/response link between the poller and the I2C master.
interface i2c_sensor_poller_if;
  import i2c_pkg::*;
  logic cmd_valid, cmd_ready, cmd_ack, rsp_valid, rsp_nack;
  i2c_op_t cmd_op;
  logic [7:0] cmd_data, rsp_data;
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_ack, input cmd_ready, rsp_valid, rsp_data, rsp_nack);
  modport slave (input cmd_valid, cmd_op, cmd_data, cmd_ack, output cmd_ready, rsp_valid, rsp_data, rsp_nack);
endinterface

// File: rtl/poll_timer.sv
// poll_timer: free-running 0..P-1 counter, tick on the last count, P = SYSCLK_FREQ/POLL_HZ.
module poll_timer #(
  parameter int unsigned SYSCLK_FREQ = 100_000_000,
  parameter int unsigned POLL_HZ = 100
) (
  input logic sclk,
  input logic rstn,
  output logic tick
);
  localparam int unsigned P = SYSCLK_FREQ / POLL_HZ;
  localparam int unsigned W = $clog2(P);
  logic [W-1:0] count;
  assign tick = count == W'(P - 1);
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: periodic pointer-write / repeated-start / multi-byte read sequencer
// driving the I2C master's byte command port; publishes samples and counts aborts/overruns.
module i2c_sensor_poller import i2c_pkg::*; #(
  parameter int unsigned SYSCLK_FREQ = 100_000_000,
  parameter int unsigned POLL_HZ = 100,
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] START_REG = 8'h3B,
  parameter int unsigned NUM_BYTES = 6
) (
  input logic sclk,
  input logic rstn,
  input logic enable,
  i2c_sensor_poller_if.master bus,
  output logic busy,
  output logic [8*NUM_BYTES-1:0] sample,
  output logic sample_valid,
  output logic err_pulse,
  output logic [7:0] err_count,
  output logic [7:0] overrun_count
);
  localparam int unsigned SB = 8 * NUM_BYTES;
  localparam int unsigned LAST = NUM_BYTES + 5;
  localparam int unsigned SW = $clog2(LAST + 1);
  localparam logic [SW-1:0] STOP_STEP = SW'(LAST);
  localparam logic [SW-1:0] FIRST_RD = SW'(5);
  poll_state_t state, state_n;
  logic [SW-1:0] step;
  logic aborting, tick, issuing, nack_hit, start;
  i2c_op_t op;
  logic [7:0] data;
  logic [SB-1:0] shadow;
  poll_timer #(.SYSCLK_FREQ(SYSCLK_FREQ), .POLL_HZ(POLL_HZ)) timer (.sclk(sclk), .rstn(rstn), .tick(tick));
  // steps 0..4 address the register pointer, then NUM_BYTES reads, then STOP
  assign op = (step == '0 || step == SW'(3)) ? START : (step < FIRST_RD) ? WRITE : (step == STOP_STEP) ? STOP : READ;
  assign data = step == SW'(1) ? {DEV_ADDR, 1'b0} : step == SW'(2) ? START_REG : step == SW'(4) ? {DEV_ADDR, 1'b1} : 8'h00;
  assign issuing = state == ISSUE || state == ABORT;
  assign bus.cmd_valid = issuing;
  assign bus.cmd_op = issuing ? op : START;
  assign bus.cmd_data = issuing ? data : 8'h00;
  assign bus.cmd_ack = issuing && op == READ && step != STOP_STEP - 1'b1;
  assign busy = state != IDLE;
  assign start = tick && enable;
  assign nack_hit = bus.rsp_nack && op == WRITE && !aborting;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? ISSUE : IDLE;
      ISSUE, ABORT: state_n = bus.cmd_ready ? WAIT : state;
      WAIT: state_n = !bus.rsp_valid ? WAIT : nack_hit ? ABORT : step != STOP_STEP ? ISSUE : aborting ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      step <= '0;
      aborting <= 1'b0;
      shadow <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      overrun_count <= '0;
    end else begin
      state <= state_n;
      sample_valid <= 1'b0;
      err_pulse <= 1'b0;
      if (start && busy) overrun_count <= overrun_count + {7'd0, ~&overrun_count};
      if (state == IDLE) begin
        step <= '0;
        aborting <= 1'b0;
      end
      if (state == WAIT && bus.rsp_valid) begin
        // shifting in leaves the first received byte in the MSBs after NUM_BYTES reads
        if (op == READ) shadow <= (shadow << 8) | SB'(bus.rsp_data);
        if (nack_hit) begin
          step <= STOP_STEP;
          aborting <= 1'b1;
        end else if (step != STOP_STEP) step <= step + 1'b1;
        else if (aborting) begin
          err_pulse <= 1'b1;
          err_count <= err_count + {7'd0, ~&err_count};
        end else begin
          sample <= shadow;
          sample_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb_i2c_sensor_poller: directed bench with a responsive I2C master model and command/sample scoreboards.
module tb_i2c_sensor_poller;
  import i2c_pkg::*;
  localparam int N = 6;
  localparam int HOLD = 20;
  localparam logic [6:0] DEV = 7'h68;
  localparam logic [7:0] REG = 8'h3B;
  localparam logic [47:0] SAMPLE = 48'h101112131415;
  logic sclk = 0, rstn = 1, enable = 0;
  logic busy, sample_valid, err_pulse;
  logic [47:0] sample;
  logic [7:0] err_count, overrun_count;
  i2c_sensor_poller_if bus();
  i2c_sensor_poller #(.SYSCLK_FREQ(10_000), .POLL_HZ(100), .DEV_ADDR(DEV), .START_REG(REG), .NUM_BYTES(N)) dut (
    .sclk(sclk), .rstn(rstn), .enable(enable), .bus(bus), .busy(busy), .sample(sample),
    .sample_valid(sample_valid), .err_pulse(err_pulse), .err_count(err_count), .overrun_count(overrun_count));
  always #5 sclk = ~sclk;
  int checks = 0, failures = 0, cyc = 0;
  logic [10:0] exp_cmd[$];
  logic [47:0] exp_smp[$];
  int cmd_idx = 0, hold_at = -1, hold_left = 0, stall_at = -1, stall_len = 0, dly = 0;
  bit nack_addr = 0, pend = 0, pnack = 0, prev_busy = 0;
  logic [7:0] pdata = 0, rd_byte = 8'h10;
  logic [10:0] cur, hold_ref;
  int sv_cnt = 0, sv_cyc = 0, err_cnt = 0, err_cyc = 0, rise_cnt = 0, rise_cyc = 0, base = 0, r = 0;
  function automatic logic [10:0] cw(i2c_op_t o, logic [7:0] d, logic a);
    return {o, d, a};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_seq();
    exp_cmd.push_back(cw(START, 8'h00, 1'b0));
    exp_cmd.push_back(cw(WRITE, {DEV, 1'b0}, 1'b0));
    exp_cmd.push_back(cw(WRITE, REG, 1'b0));
    exp_cmd.push_back(cw(START, 8'h00, 1'b0));
    exp_cmd.push_back(cw(WRITE, {DEV, 1'b1}, 1'b0));
    for (int k = 0; k < N; k++) exp_cmd.push_back(cw(READ, 8'h00, k != N - 1));
    exp_cmd.push_back(cw(STOP, 8'h00, 1'b0));
    exp_smp.push_back(SAMPLE);
  endtask
  task automatic step();
    @(negedge sclk);
    #1;
  endtask
  always @(posedge sclk or negedge rstn) cyc <= !rstn ? 0 : cyc + 1;
  // master model and output monitor, both acting on the falling edge
  always @(negedge sclk) begin
    bus.rsp_valid = 0;
    bus.rsp_nack = 0;
    bus.rsp_data = 0;
    bus.cmd_ready = 1;
    if (!rstn) begin
      pend = 0;
      rd_byte = 8'h10;
      prev_busy = 0;
    end else begin
      if (pend) begin
        if (dly > 0) dly--;
        else begin
          bus.rsp_valid = 1;
          bus.rsp_nack = pnack;
          bus.rsp_data = pdata;
          pend = 0;
        end
      end else if (bus.cmd_valid) begin
        cur = {bus.cmd_op, bus.cmd_data, bus.cmd_ack};
        if (cmd_idx == hold_at && hold_left > 0) begin
          if (hold_left == HOLD) hold_ref = cur;
          else chk("hold_stable", 64'(cur), 64'(hold_ref));
          bus.cmd_ready = 0;
          hold_left--;
        end else begin
          chk("cmd_expected", 64'(exp_cmd.size() != 0), 1);
          if (exp_cmd.size() != 0) chk($sformatf("cmd%0d", cmd_idx), 64'(cur), 64'(exp_cmd.pop_front()));
          pend = 1;
          dly = cmd_idx == stall_at ? stall_len : 0;
          pnack = nack_addr && bus.cmd_op == WRITE && bus.cmd_data == {DEV, 1'b0};
          if (pnack) nack_addr = 0;
          pdata = bus.cmd_op == READ ? rd_byte : 8'h00;
          if (bus.cmd_op == READ) rd_byte++;
          if (bus.cmd_op == STOP) rd_byte = 8'h10;
          cmd_idx++;
        end
      end
      if (sample_valid) begin
        sv_cnt++;
        sv_cyc = cyc;
        chk("sample_expected", 64'(exp_smp.size() != 0), 1);
        if (exp_smp.size() != 0) chk("sample", 64'(sample), 64'(exp_smp.pop_front()));
      end
      if (err_pulse) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (busy && !prev_busy) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      prev_busy = busy;
    end
  end
  initial begin
    #2 rstn = 0;
    repeat (3) step();
    chk("rst_outs", 64'({busy, bus.cmd_valid, sample_valid, err_pulse, err_count, overrun_count}), 0);
    chk("rst_sample", 64'(sample), 0);
    enable = 1;
    push_seq();
    rstn = 1;
    for (int i = 0; i < 300 && sv_cnt < 1; i++) step();
    chk("t1_sv", sv_cnt, 1);
    chk("t1_start_cyc", rise_cyc, 100);
    chk("t1_sv_cyc", sv_cyc, 124);
    step();
    chk("t1_sv_pulse", 64'(sample_valid), 0);
    chk("t1_idle", 64'(busy), 0);
    chk("t1_sample_held", 64'(sample), 64'(SAMPLE));
    nack_addr = 1;
    exp_cmd.push_back(cw(START, 8'h00, 1'b0));
    exp_cmd.push_back(cw(WRITE, {DEV, 1'b0}, 1'b0));
    exp_cmd.push_back(cw(STOP, 8'h00, 1'b0));
    for (int i = 0; i < 300 && err_cnt < 1; i++) step();
    chk("t2_err_pulses", err_cnt, 1);
    chk("t2_err_cyc", err_cyc, 206);
    chk("t2_err_count", 64'(err_count), 1);
    chk("t2_sample_kept", 64'(sample), 64'(SAMPLE));
    chk("t2_no_sv", sv_cnt, 1);
    step();
    chk("t2_err_pulse_width", 64'(err_pulse), 0);
    chk("t2_idle", 64'(busy), 0);
    hold_at = cmd_idx + 2;
    hold_left = HOLD;
    push_seq();
    for (int i = 0; i < 300 && sv_cnt < 2; i++) step();
    chk("t3_sv", sv_cnt, 2);
    chk("t3_hold_done", hold_left, 0);
    chk("t3_latency", sv_cyc - rise_cyc, 24 + HOLD);
    stall_at = cmd_idx + 5;
    stall_len = 250;
    push_seq();
    for (int i = 0; i < 600 && sv_cnt < 3; i++) step();
    stall_at = -1;
    chk("t4_sv", sv_cnt, 3);
    chk("t4_overrun", 64'(overrun_count), 2);
    repeat (20) step();
    chk("t4_single_sv", sv_cnt, 3);
    push_seq();
    base = cmd_idx;
    for (int i = 0; i < 300 && cmd_idx < base + 9; i++) step();
    chk("t5_reached_read3", cmd_idx, base + 9);
    step();
    rstn = 0;
    #1;
    chk("t5_rst_outs", 64'({busy, bus.cmd_valid, sample_valid, err_pulse, err_count, overrun_count}), 0);
    chk("t5_rst_sample", 64'(sample), 0);
    exp_cmd.delete();
    exp_smp.delete();
    repeat (3) step();
    push_seq();
    rstn = 1;
    for (int i = 0; i < 300 && sv_cnt < 4; i++) step();
    chk("t5_sv", sv_cnt, 4);
    chk("t5_start_cyc", rise_cyc, 100);
    chk("t5_sv_cyc", sv_cyc, 124);
    push_seq();
    base = cmd_idx;
    for (int i = 0; i < 300 && cmd_idx < base + 3; i++) step();
    enable = 0;
    for (int i = 0; i < 300 && sv_cnt < 5; i++) step();
    chk("t6_sv", sv_cnt, 5);
    r = rise_cnt;
    repeat (250) step();
    chk("t6_no_restart", rise_cnt, r);
    chk("t6_overrun", 64'(overrun_count), 0);
    chk("t6_idle", 64'(busy), 0);
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("sample_queue_empty", exp_smp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
